column_config_loader: RTL and testbench

COLUMN_CONFIG_LOADER -- requirements
Module: column_config_loader

---
 rtl/column_config_loader.sv | 97 +++++++++
 tb/tb_column_config_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_config_loader.sv
// column_config_loader
//   Streams a column configuration bitstream into a shadow register one word at a
//   time and commits it to config_out only once every word has arrived, so the
//   logic column never sees a partially loaded configuration.
//
// Ports
//   clock       : single clock, all state changes on the rising edge
//   reset       : synchronous active-high reset, highest priority
//   start       : one-cycle request to begin (or restart) a load
//   data_in     : bitstream word
//   data_valid  : data_in holds a valid word
//   data_ready  : loader accepts a word this cycle (LOAD only)
//   config_out  : committed configuration
//   config_done : config_out holds a complete committed load
//   busy        : a load is in progress (LOAD only)
//   word_count  : words accepted in the current load
module column_config_loader #(
    parameter int unsigned CONFIG_WIDTH = 4192,
    parameter int unsigned WORD_WIDTH   = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_done,
    output logic                    busy,
    output logic [7:0]              word_count
);

    localparam int unsigned NumWords = CONFIG_WIDTH / WORD_WIDTH;
    localparam logic [7:0]  LastIdx  = 8'(NumWords - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } state_t;

    state_t                  state;
    logic [CONFIG_WIDTH-1:0] shadow;
    logic [CONFIG_WIDTH-1:0] shadow_next;
    logic                    last_word;

    // Shadow with the current word merged in; also used as the commit value so
    // the final word reaches config_out on the same edge that accepts it.
    always_comb begin
        shadow_next = shadow;
        shadow_next[int'(word_count) * WORD_WIDTH +: WORD_WIDTH] = data_in;
    end

    assign last_word  = (word_count == LastIdx);
    assign data_ready = (state == StLoad);
    assign busy       = (state == StLoad);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= StIdle;
            shadow      <= '0;
            config_out  <= '0;
            config_done <= 1'b0;
            word_count  <= '0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    // data_valid/data_in are ignored outside LOAD
                    if (start) begin
                        state       <= StLoad;
                        shadow      <= '0;
                        word_count  <= '0;
                        config_done <= 1'b0;
                    end
                end
                StLoad: begin
                    // start wins over any word presented in the same cycle,
                    // including the final one, so no commit can slip through
                    if (start) begin
                        shadow     <= '0;
                        word_count <= '0;
                    end else if (data_valid) begin
                        shadow     <= shadow_next;
                        word_count <= word_count + 8'd1;
                        if (last_word) begin
                            config_out  <= shadow_next;
                            config_done <= 1'b1;
                            state       <= StDone;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_column_config_loader.sv
// tb_column_config_loader
//   Directed-vector bench for column_config_loader at default parameters.
//   Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_column_config_loader;

    localparam int unsigned CW = 4192;
    localparam int unsigned WW = 32;
    localparam int unsigned NW = CW / WW;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [WW-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic [CW-1:0] config_out;
    logic          config_done;
    logic          busy;
    logic [7:0]    word_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CW-1:0] exp_cfg;
    int            bad;

    column_config_loader #(
        .CONFIG_WIDTH(CW),
        .WORD_WIDTH  (WW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .config_out (config_out),
        .config_done(config_done),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Index of first word where act and exp differ, or -1.
    function automatic int first_bad_word(input logic [CW-1:0] act, input logic [CW-1:0] exp);
        for (int i = 0; i < int'(NW); i++) begin
            if (act[i*WW +: WW] !== exp[i*WW +: WW]) return i;
        end
        return -1;
    endfunction

    // Present one word with data_valid held high for one edge.
    task automatic send_word(input logic [WW-1:0] d);
        data_in    = d;
        data_valid = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; data_valid = 1'b1; data_in = 32'hFFFF_FFFF;
        tick(); tick();
        reset = 1'b0; data_valid = 1'b0;
        n_checks++;
        if (config_out !== '0) begin n_fail++; $display("FAIL reset_config_out nonzero"); end
        n_checks++;
        if (config_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", config_done); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++;
        if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", data_ready); end
        n_checks++;
        if (word_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", word_count); end
        // Idle ignores data
        data_valid = 1'b1; tick(); tick(); data_valid = 1'b0;
        n_checks++;
        if (word_count !== 8'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_ignore count=%0d busy=%b exp 0/0", word_count, busy);
        end
    endtask

    task automatic test_full_load();
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || data_ready !== 1'b1 || word_count !== 8'd0) begin
            n_fail++;
            $display("FAIL start_load busy=%b ready=%b count=%0d exp 1/1/0", busy, data_ready, word_count);
        end
        for (int k = 0; k < int'(NW); k++) begin
            exp_cfg[k*WW +: WW] = WW'(k);
            send_word(WW'(k));
            if (k == int'(NW) - 2) begin
                n_checks++;
                if (config_done !== 1'b0 || config_out !== '0 || word_count !== 8'd130) begin
                    n_fail++;
                    $display("FAIL full_before_last done=%b count=%0d exp 0/130", config_done, word_count);
                end
            end
        end
        data_valid = 1'b0;
        n_checks++;
        if (config_done !== 1'b1) begin n_fail++; $display("FAIL full_done got=%b exp=1", config_done); end
        n_checks++;
        if (config_out[31:0] !== 32'd0 || config_out[63:32] !== 32'd1 || config_out[4191:4160] !== 32'd130) begin
            n_fail++;
            $display("FAIL full_slices w0=%0d w1=%0d w130=%0d exp 0/1/130",
                     config_out[31:0], config_out[63:32], config_out[4191:4160]);
        end
        bad = first_bad_word(config_out, exp_cfg);
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL full_vector word=%0d got=%h exp=%h", bad, config_out[bad*WW +: WW], exp_cfg[bad*WW +: WW]);
        end
        n_checks++;
        if (word_count !== 8'd131 || data_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_status count=%0d ready=%b busy=%b exp 131/0/0", word_count, data_ready, busy);
        end
        // DONE ignores data and holds indefinitely
        for (int i = 0; i < 10; i++) send_word(32'hDEAD_BEEF);
        data_valid = 1'b0;
        n_checks++;
        if (first_bad_word(config_out, exp_cfg) >= 0 || config_done !== 1'b1 || word_count !== 8'd131) begin
            n_fail++;
            $display("FAIL done_hold done=%b count=%0d exp 1/131", config_done, word_count);
        end
    endtask

    task automatic test_throttled();
        logic busy_ok;
        busy_ok = 1'b1;
        pulse_start();
        n_checks++;
        if (config_done !== 1'b0 || word_count !== 8'd0) begin
            n_fail++; $display("FAIL restart_from_done done=%b count=%0d exp 0/0", config_done, word_count);
        end
        for (int c = 0; c < 2 * int'(NW) - 1; c++) begin
            data_valid = (c % 2 == 0);
            data_in    = (c % 2 == 0) ? WW'(c / 2) : 32'hBAD0_0000;
            tick();
            if (c < 2 * int'(NW) - 2 && busy !== 1'b1) busy_ok = 1'b0;
            if (c == 2 * int'(NW) - 3) begin
                n_checks++;
                if (config_done !== 1'b0) begin
                    n_fail++; $display("FAIL throttle_early_done got=%b exp=0", config_done);
                end
            end
        end
        data_valid = 1'b0;
        n_checks++;
        if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL throttle_busy got=0 exp=1 throughout"); end
        n_checks++;
        if (config_done !== 1'b1 || word_count !== 8'd131) begin
            n_fail++; $display("FAIL throttle_done done=%b count=%0d exp 1/131", config_done, word_count);
        end
        bad = first_bad_word(config_out, exp_cfg);
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL throttle_vector word=%0d got=%h exp=%h", bad, config_out[bad*WW +: WW], exp_cfg[bad*WW +: WW]);
        end
    endtask

    task automatic test_no_partial();
        pulse_start();
        for (int k = 0; k < int'(NW); k++) send_word(32'hAAAA_AAAA);
        data_valid = 1'b0;
        for (int k = 0; k < int'(NW); k++) exp_cfg[k*WW +: WW] = 32'hAAAA_AAAA;
        n_checks++;
        if (config_done !== 1'b1) begin n_fail++; $display("FAIL loadA_done got=%b exp=1", config_done); end
        pulse_start();
        for (int k = 0; k < 60; k++) send_word(32'h5555_5555);
        data_valid = 1'b0;
        tick();
        bad = first_bad_word(config_out, exp_cfg);
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL partial_visible word=%0d got=%h exp=%h", bad, config_out[bad*WW +: WW], exp_cfg[bad*WW +: WW]);
        end
        n_checks++;
        if (config_done !== 1'b0 || word_count !== 8'd60) begin
            n_fail++; $display("FAIL partial_status done=%b count=%0d exp 0/60", config_done, word_count);
        end
    endtask

    task automatic test_restart();
        // Continues from LOAD left by test_no_partial
        pulse_start();
        for (int k = 0; k < 70; k++) send_word(WW'(k + 1000));
        data_in = 32'hDEAD_0001; data_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; data_valid = 1'b0;
        n_checks++;
        if (word_count !== 8'd0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL restart_count count=%0d busy=%b exp 0/1", word_count, busy);
        end
        for (int k = 0; k < int'(NW); k++) begin
            exp_cfg[k*WW +: WW] = WW'(k) ^ 32'h1234_0000;
            send_word(WW'(k) ^ 32'h1234_0000);
        end
        data_valid = 1'b0;
        bad = first_bad_word(config_out, exp_cfg);
        n_checks++;
        if (bad >= 0 || config_done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_commit word=%0d done=%b", bad, config_done);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        for (int k = 0; k < 100; k++) send_word(WW'(k + 7));
        reset = 1'b1; data_valid = 1'b0;
        tick();
        reset = 1'b0;
        n_checks++;
        if (config_out !== '0 || word_count !== 8'd0 || busy !== 1'b0 || config_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid count=%0d busy=%b done=%b cfg_nonzero=%b exp 0/0/0/0",
                     word_count, busy, config_done, |config_out);
        end
        for (int i = 0; i < 3; i++) send_word(32'hCAFE_F00D);
        data_valid = 1'b0;
        n_checks++;
        if (data_ready !== 1'b0 || word_count !== 8'd0 || config_out !== '0) begin
            n_fail++; $display("FAIL idle_after_reset ready=%b count=%0d exp 0/0", data_ready, word_count);
        end
    endtask

    task automatic test_start_final();
        pulse_start();
        for (int k = 0; k < int'(NW) - 1; k++) send_word(WW'(k));
        data_in = WW'(NW - 1); data_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; data_valid = 1'b0;
        n_checks++;
        if (config_done !== 1'b0 || word_count !== 8'd0 || busy !== 1'b1 || config_out !== '0) begin
            n_fail++;
            $display("FAIL start_vs_final done=%b count=%0d busy=%b exp 0/0/1", config_done, word_count, busy);
        end
        // Long data_valid gap: no timeout, stays in LOAD
        for (int i = 0; i < 40; i++) tick();
        n_checks++;
        if (busy !== 1'b1 || word_count !== 8'd0 || config_done !== 1'b0) begin
            n_fail++; $display("FAIL gap_hold busy=%b count=%0d exp 1/0", busy, word_count);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; data_in = '0; data_valid = 1'b0;
        exp_cfg = '0;
        test_reset();
        test_full_load();
        test_throttled();
        test_no_partial();
        test_restart();
        test_reset_mid();
        test_start_final();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
